imm_encoder: RTL

Pipelined immediate encoder: the inverse of the core's immediate extend decoder. It takes a base instruction word, a 32-bit immediate and a format selector, and packs the immediate into the format's scattered bit fields. It also checks that the value is representable. It sits in the boot/test instruction-memory loader path, between the program generator and the instruction-memory write port.

---
 rtl/imm_encoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined packer of a 32-bit immediate into I/S/B/J instruction fields.
// Range/alignment checking (out_err, err_cnt) is built only when IMM_ENC_RANGE_CHECK_EN is defined.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] base_instr,
    input  logic [31:0] imm,
    input  logic [1:0]  immsrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    input  logic        clr_cnt,
    output logic [15:0] enc_cnt,
    output logic [15:0] err_cnt
);
    typedef enum logic [1:0] {FmtI = 2'b00, FmtS = 2'b01, FmtB = 2'b10, FmtJ = 2'b11} fmt_e;

    logic        r_a_valid;
    logic [31:0] r_a_instr;
    logic [31:0] r_a_imm;
    fmt_e        r_a_src;
    logic        r_b_valid;
    logic [31:0] r_b_instr;
    logic [15:0] r_enc_cnt;

    logic        w_b_free;
    logic        w_a_load;
    logic        w_b_load;
    logic        w_out_hs;
    logic [31:0] w_pack;

    assign w_b_free = !r_b_valid || out_ready;
    assign in_ready = !r_a_valid || w_b_free;
    assign w_a_load = in_valid && in_ready;
    assign w_b_load = r_a_valid && w_b_free;
    assign w_out_hs = r_b_valid && out_ready;

    // Immediate-field bits of base_instr are overwritten; everything else passes through.
    always_comb begin
        w_pack = r_a_instr;
        unique case (r_a_src)
            FmtI: w_pack[31:20] = r_a_imm[11:0];
            FmtS: begin
                w_pack[31:25] = r_a_imm[11:5];
                w_pack[11:7]  = r_a_imm[4:0];
            end
            FmtB: begin
                w_pack[31]    = r_a_imm[12];
                w_pack[30:25] = r_a_imm[10:5];
                w_pack[11:8]  = r_a_imm[4:1];
                w_pack[7]     = r_a_imm[11];
            end
            FmtJ: begin
                w_pack[31]    = r_a_imm[20];
                w_pack[30:21] = r_a_imm[10:1];
                w_pack[20]    = r_a_imm[11];
                w_pack[19:12] = r_a_imm[19:12];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_instr <= '0;
            r_a_imm   <= '0;
            r_a_src   <= FmtI;
        end else if (in_ready) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_instr <= base_instr;
                r_a_imm   <= imm;
                r_a_src   <= fmt_e'(immsrc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_instr <= '0;
        end else if (w_b_free) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_instr <= w_pack;
            end
        end
    end

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_cnt <= '0;
        end else if (clr_cnt) begin
            r_enc_cnt <= '0;
        end else if (w_out_hs && r_enc_cnt != 16'hFFFF) begin
            r_enc_cnt <= r_enc_cnt + 16'd1;
        end
    end

    assign out_valid = r_b_valid;
    assign out_instr = r_b_instr;
    assign enc_cnt   = r_enc_cnt;

`ifdef IMM_ENC_RANGE_CHECK_EN
    logic        r_b_err;
    logic [15:0] r_err_cnt;
    logic        w_err;

    // Representable iff the bits above the top encoded bit all match it (sign extension).
    always_comb begin
        w_err = 1'b0;
        unique case (r_a_src)
            FmtI, FmtS: w_err = !(&r_a_imm[31:11] || ~|r_a_imm[31:11]);
            FmtB:       w_err = !(&r_a_imm[31:12] || ~|r_a_imm[31:12]) || r_a_imm[0];
            FmtJ:       w_err = !(&r_a_imm[31:20] || ~|r_a_imm[31:20]) || r_a_imm[0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_err <= 1'b0;
        end else if (w_b_load) begin
            r_b_err <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_out_hs && r_b_err && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign out_err = r_b_err;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_imm;
    assign w_unused_imm = ^r_a_imm[31:21];
    assign out_err = 1'b0;
    assign err_cnt = 16'd0;
`endif

endmodule
